logic_seq_unit: RTL and testbench

LOGIC_SEQ_UNIT -- requirements
Module: logic_seq_unit

---
 rtl/logic_seq_pkg.sv | 33 +++
 rtl/logic_seq_unit_slice.sv | 27 ++
 rtl/logic_seq_unit.sv | 145 ++++++++++++++
 tb/tb_logic_seq_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_seq_pkg.sv
// Shared types and constants for the sliced bitwise logic unit.
// Contents: DATA_W, op_e (AND/OR/XOR/NOR), state_e (IDLE/BUSY/DONE),
// XOR_EN build flag and an op_supported() helper.
// Build option: define LOGIC_SEQ_XOR_EN to enable the XOR and NOR ops.
package logic_seq_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

`ifdef LOGIC_SEQ_XOR_EN
    localparam bit XOR_EN = 1'b1;
`else
    localparam bit XOR_EN = 1'b0;
`endif

    // AND/OR are always present; XOR/NOR only when the build enables them.
    function automatic logic op_supported(input op_e op);
        return (op == OP_AND) || (op == OP_OR) || XOR_EN;
    endfunction

endpackage

// File: rtl/logic_seq_unit_slice.sv
// logic_slice: combinational SLICE_W-bit bitwise operator.
// Ports: op (operation), a/b (operand slices), res_c (slice result).
// Build option: LOGIC_SEQ_XOR_EN (via logic_seq_pkg::XOR_EN) enables XOR/NOR;
// without it those ops yield an all-zero slice.
module logic_slice
    import logic_seq_pkg::*;
#(
    parameter int unsigned SLICE_W = 8
) (
    input  op_e                op,
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic [SLICE_W-1:0] res_c
);

    always_comb begin
        res_c = '0;
        case (op)
            OP_AND: res_c = a & b;
            OP_OR:  res_c = a | b;
            OP_XOR: if (XOR_EN) res_c = a ^ b;
            OP_NOR: if (XOR_EN) res_c = ~(a | b);
            default: res_c = '0;
        endcase
    end

endmodule

// File: rtl/logic_seq_unit.sv
// logic_seq_unit: sequential bitwise unit computing one SLICE_W-bit slice of
// a 32-bit AND/OR/XOR/NOR result per cycle, with valid/ready handshakes.
// Ports: clk, reset (async, active-high); in_valid/in_ready, op, a, b
// (request side); out_valid/out_ready, result, zero, illegal (response side).
// Build option: LOGIC_SEQ_XOR_EN enables XOR/NOR; otherwise those ops complete
// with result=0, zero=1, illegal=1 at the normal latency.
module logic_seq_unit
    import logic_seq_pkg::*;
#(
    parameter int unsigned SLICE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              illegal
);

    localparam int unsigned N_SLICES = DATA_W / SLICE_W;
    localparam int unsigned CNT_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SLICES - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    op_e                 op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_q, zero_d;
    logic                illegal_q, illegal_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic [SLICE_W-1:0]  slice_a_c, slice_b_c, slice_res_c;

    // Select the operand slice addressed by the slice counter.
    always_comb begin
        slice_a_c = '0;
        slice_b_c = '0;
        for (int unsigned k = 0; k < N_SLICES; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                slice_a_c = a_q[k*SLICE_W +: SLICE_W];
                slice_b_c = b_q[k*SLICE_W +: SLICE_W];
            end
        end
    end

    logic_slice #(
        .SLICE_W (SLICE_W)
    ) u_slice (
        .op    (op_q),
        .a     (slice_a_c),
        .b     (slice_b_c),
        .res_c (slice_res_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d     = op_e'(op);
                    a_d      = a;
                    b_d      = b;
                    cnt_d    = '0;
                    result_d = '0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int unsigned k = 0; k < N_SLICES; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        result_d[k*SLICE_W +: SLICE_W] = slice_res_c;
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
                // Flags are judged on the fully assembled result, including this slice.
                if (cnt_q == LAST_CNT) begin
                    state_d   = ST_DONE;
                    zero_d    = (result_d == '0);
                    illegal_d = !op_supported(op_q);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake outputs are registered decodes of the next state.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_AND;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_logic_seq_unit.sv
// Self-checking bench for logic_seq_unit: directed scenarios plus randomized
// operations checked against a whole-word behavioural model.
module tb_logic_seq_unit;

    localparam int unsigned SW = 8;
    localparam int unsigned N  = 32 / SW;

`ifdef LOGIC_SEQ_XOR_EN
    localparam bit MDL_XOR_EN = 1'b1;
`else
    localparam bit MDL_XOR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  o;
        logic [31:0] x;
        logic [31:0] y;
    } txn_t;

    always #5 clk = ~clk;

    logic_seq_unit #(.SLICE_W(SW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return MDL_XOR_EN ? (x ^ y) : 32'd0;
            default: return MDL_XOR_EN ? ~(x | y) : 32'd0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [1:0] o);
        return !MDL_XOR_EN && (o >= 2'd2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, scramble inputs, measure latency, check
    // outputs, hold off the consumer for 'hold' cycles, then retire.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int hold);
        logic [31:0] er;
        int          cyc;
        er = ref_result(o, x, y);
        @(negedge clk);
        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        op       = 2'($urandom);
        a        = $urandom;
        b        = $urandom;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ".latency"}, 32'(cyc), 32'(N));
        check({tag, ".result"}, result, er);
        check({tag, ".zero"}, 32'(zero), 32'(er == 32'd0));
        check({tag, ".illegal"}, 32'(illegal), 32'(ref_illegal(o)));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, ".hold_result"}, result, er);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".retired_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".retired_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        txn_t q[$];
        txn_t cur;
        txn_t exp_t;
        int   acc;
        int   ret;
        int   last_acc;
        int   cyc;
        bit   pend;

        // Reset values while reset is held.
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.zero", 32'(zero), 32'd0);
        check("rst.illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("and", 2'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        run_op("or_zero", 2'd1, 32'h0, 32'h0, 0);
        run_op("backpressure", 2'd0, $urandom, $urandom, 10);
        run_op("xor", 2'd2, 32'hFFFF_0000, 32'hFF00_FF00, 1);

        // Reset while the unit is computing slice 2.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 2'd1;
        a        = 32'h1234_5678;
        b        = 32'h8765_4321;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        check("midrst.result", result, 32'd0);
        check("midrst.zero", 32'(zero), 32'd0);
        check("midrst.illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < int'(N) + 3; i++) begin
            @(negedge clk);
            check("midrst.no_resume", 32'(out_valid), 32'd0);
        end
        run_op("nor_after_rst", 2'd3, 32'h0, 32'h0, 0);

        // Randomized single operations with random backpressure.
        for (int i = 0; i < 8; i++) begin
            run_op("rand", 2'($urandom_range(0, 3)), $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        // Back-to-back: in_valid and out_ready held high.
        acc      = 0;
        ret      = 0;
        last_acc = -1;
        cyc      = 0;
        pend     = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = 2'($urandom);
        a         = $urandom;
        b         = $urandom;
        while (ret < 6 && cyc < 200) begin
            if (pend) begin
                pend = 1'b0;
                if (acc < 6) begin
                    op = 2'($urandom);
                    a  = $urandom;
                    b  = $urandom;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                check("b2b.expected_pending", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    exp_t = q.pop_front();
                    check("b2b.result", result, ref_result(exp_t.o, exp_t.x, exp_t.y));
                    check("b2b.zero", 32'(zero), 32'(ref_result(exp_t.o, exp_t.x, exp_t.y) == 32'd0));
                    check("b2b.illegal", 32'(illegal), 32'(ref_illegal(exp_t.o)));
                end
                ret++;
            end
            if (in_valid && in_ready) begin
                if (last_acc >= 0) begin
                    check("b2b.accept_interval", 32'(cyc - last_acc), 32'(N + 2));
                end
                last_acc = cyc;
                cur.o = op;
                cur.x = a;
                cur.y = b;
                q.push_back(cur);
                acc++;
                pend = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b.accepted", 32'(acc), 32'd6);
        check("b2b.retired", 32'(ret), 32'd6);
        check("b2b.leftover", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
